// File: rtl/saed90_pipe_adder.sv
// Pipelined ripple-carry add/subtract unit with a valid/ready handshake and per-stage bubble collapse.
// Define SAED90_PIPE_OVF_EN to build the signed-overflow output; otherwise out_OVF is tied to 0.
module saed90_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             in_CLK,
  input  logic             in_RSTB,
  input  logic             in_VALID,
  output logic             out_READY,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_CI,
  input  logic             in_SUB,
  output logic             out_VALID,
  input  logic             in_READY,
  output logic [WIDTH-1:0] out_S,
  output logic             out_CO,
  output logic             out_OVF
);

  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0] valid_vec;
  logic [STAGES:0]   load;
  logic [WIDTH-1:0]  b_cap;
  logic              c_cap;

  // Subtract is A + ~B + 1, so CI is overridden rather than combined.
  assign b_cap = in_SUB ? ~in_B : in_B;
  assign c_cap = in_SUB | in_CI;

  // A stage may load when it is empty or when the stage after it is emptying this cycle.
  always_comb begin
    load         = '0;
    load[STAGES] = in_READY;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = ~valid_vec[k] | load[k+1];
    end
  end

  assign out_READY = load[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stg
    localparam int LO = gi * SW;
    localparam int HI = LO + SW;

    logic          v_src;
    logic [SW-1:0] a_sl;
    logic [SW-1:0] b_sl;
    logic [SW-1:0] s_sl;
    logic          c_in;
    logic          c_out;
    logic [HI-1:0] sum_d;
    logic [HI-1:0] sum_q;
    logic          carry_q;
    logic          valid_q;
    logic          valid_d;
    logic          take;

    if (gi == 0) begin : g_src
      assign v_src = in_VALID;
      assign a_sl  = in_A[SW-1:0];
      assign b_sl  = b_cap[SW-1:0];
      assign c_in  = c_cap;
      assign sum_d = s_sl;
    end else begin : g_src
      assign v_src = g_stg[gi-1].valid_q;
      assign a_sl  = g_stg[gi-1].g_ops.a_q[SW-1:0];
      assign b_sl  = g_stg[gi-1].g_ops.b_q[SW-1:0];
      assign c_in  = g_stg[gi-1].carry_q;
      assign sum_d = {s_sl, g_stg[gi-1].sum_q};
    end

    // One full-adder cell per bit; this ripple is the per-stage critical path.
    always_comb begin
      logic c_rip;
      c_rip = c_in;
      s_sl  = '0;
      for (int i = 0; i < SW; i++) begin
        s_sl[i] = a_sl[i] ^ b_sl[i] ^ c_rip;
        c_rip   = (a_sl[i] & b_sl[i]) | (c_rip & (a_sl[i] ^ b_sl[i]));
      end
      c_out = c_rip;
    end

    assign take      = load[gi] & v_src;
    assign valid_d   = load[gi] ? v_src : valid_q;
    assign valid_vec[gi] = valid_q;

    always_ff @(posedge in_CLK or negedge in_RSTB) begin
      if (!in_RSTB) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
        if (take) begin
          sum_q   <= sum_d;
          carry_q <= c_out;
        end
      end
    end

    // Operand slices still to be added travel with the beat; the last stage needs none.
    if (HI < WIDTH) begin : g_ops
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;
      logic [WIDTH-HI-1:0] a_d;
      logic [WIDTH-HI-1:0] b_d;

      if (gi == 0) begin : g_nxt
        assign a_d = in_A[WIDTH-1:HI];
        assign b_d = b_cap[WIDTH-1:HI];
      end else begin : g_nxt
        assign a_d = g_stg[gi-1].g_ops.a_q[WIDTH-LO-1:SW];
        assign b_d = g_stg[gi-1].g_ops.b_q[WIDTH-LO-1:SW];
      end

      always_ff @(posedge in_CLK or negedge in_RSTB) begin
        if (!in_RSTB) begin
          a_q <= '0;
          b_q <= '0;
        end else if (take) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef SAED90_PIPE_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit, so no extra tap is needed.
    if (gi == STAGES - 1) begin : g_ovf
      logic ovf_q;
      logic ovf_d;

      assign ovf_d = a_sl[SW-1] ^ b_sl[SW-1] ^ s_sl[SW-1] ^ c_out;

      always_ff @(posedge in_CLK or negedge in_RSTB) begin
        if (!in_RSTB) begin
          ovf_q <= 1'b0;
        end else if (take) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign out_VALID = valid_vec[STAGES-1];
  assign out_S     = g_stg[STAGES-1].sum_q;
  assign out_CO    = g_stg[STAGES-1].carry_q;

`ifdef SAED90_PIPE_OVF_EN
  assign out_OVF = g_stg[STAGES-1].g_ovf.ovf_q;
`else
  assign out_OVF = 1'b0;
`endif

endmodule

// File: doc/saed90_pipe_adder.md
# saed90_pipe_adder

Parametrised, pipelined two's-complement add/subtract unit for the SAED90 cell-library test designs. It generalises the single-bit full/half-adder cells to a WIDTH-bit carry-ripple datapath split into STAGES registered slices. It adds a subtract mode and a valid/ready handshake with per-stage bubble collapsing. It maps to FADDX/HADDX/MUX21 cells plus asynchronously reset flops.

## Interface

Parameters:
- WIDTH, 16, operand and sum width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline slices; each slice adds WIDTH/STAGES bits; 1 ≤ STAGES ≤ WIDTH.

Ports:
- in_CLK  input  1  clock; all state changes on rising edge.
- in_RSTB  input  1  asynchronous, active-low reset.
- in_VALID  input  1  upstream beat present.
- out_READY  output  1  unit can accept a beat this cycle.
- in_A  input  WIDTH  operand A.
- in_B  input  WIDTH  operand B.
- in_CI  input  1  carry-in; ignored when in_SUB=1.
- in_SUB  input  1  0: A+B+CI; 1: A+~B+1, i.e. A−B.
- out_VALID  output  1  result beat present.
- in_READY  input  1  downstream accepts the result.
- out_S  output  WIDTH  sum / difference modulo 2^WIDTH.
- out_CO  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- out_OVF  output  1  signed overflow (see Configuration).

## Operation

- Accept: a beat is accepted on a rising edge where in_VALID=1 and out_READY=1. Operand B is inverted and the carry-in forced to 1 at capture when in_SUB=1.
- Stage k (0..STAGES-1) holds a valid bit, the completed low sum slices 0..k, a carry, and the not-yet-added high operand slices. Stage k adds slice k using the carry registered by stage k−1. Stage 0 uses the captured carry-in.
- The last stage register drives out_S, out_CO and out_OVF directly. There is no combinational path from in_A/in_B to the outputs.
- Stage k may load when its valid bit is 0, or when stage k+1 loads in the same cycle. For the last stage, "stage k+1 loads" means in_READY=1.
- out_READY is the load condition of stage 0. It is combinational from in_READY and the valid bits.
- A bubble (valid=0) in any stage is filled even while the output is stalled. The pipeline holds at most STAGES beats.
- Beats leave in acceptance order. No beat is dropped or duplicated.
- A stalled output (out_VALID=1, in_READY=0) holds out_S, out_CO and out_OVF stable.
- Registers whose valid bit is 0 retain their data; only the valid bit is meaningful.

## Timing

- Reset values: all valid bits 0, out_VALID=0, out_S=0, out_CO=0, out_OVF=0.
- out_READY=1 immediately after reset, because the pipeline is empty.
- Reset assertion takes effect asynchronously and discards in-flight beats. Release is synchronous to in_CLK in use; the first accept is possible on the first rising edge after in_RSTB rises.
- Latency: a beat accepted on edge n gives out_VALID=1 after edge n+STAGES−1, provided there is no stall. With STAGES=1 the result is valid after the accepting edge.
- Throughput: one beat per cycle while in_READY=1.
- Simultaneous accept and emit when full: if in_READY=1 and the pipeline is full, out_READY=1 in the same cycle and both transfers occur.
- Full with a stall: out_READY=0 when all STAGES valid bits are 1 and in_READY=0.
- Carry chain per stage is WIDTH/STAGES FADDX cells. This is the critical path.

## Configuration

- Macro: SAED90_PIPE_OVF_EN.
- Defined: out_OVF = (carry into MSB) XOR (carry out of MSB) for the beat at the output. It is registered with out_S and follows the same stall rules.
- Not defined: no overflow logic is built and out_OVF is tied to 0. The port remains, so the interface is unchanged.

## Test plan

All scenarios use WIDTH=16 and STAGES=4.

- **Basic add:** A=0x1234, B=0x4321, CI=0, SUB=0, single beat with in_READY=1. Expect out_VALID after edge n+3, S=0x5555, CO=0, OVF=0.
- **Full carry ripple:** A=0xFFFF, B=0x0001, CI=0. Expect S=0x0000, CO=1. Then A=0xFFFF, B=0x0000, CI=1 gives the same result.
- **Subtract:** A=0x0005, B=0x0007, SUB=1, CI=1 (ignored). Expect S=0xFFFE, CO=0, OVF=0.
- **Subtract overflow:** A=0x8000, B=0x0001, SUB=1. Expect S=0x7FFF, CO=1, OVF=1 with the macro defined and OVF=0 without it.
- **Stall and bubble collapse:** stream 8 back-to-back beats (A=i, B=i, i=0..7) with in_READY=0 from cycle 2 to cycle 9. Expect out_READY=0 once exactly 4 beats are held and out_S stable during the stall. After in_READY returns to 1, expect all 8 sums 0,2,..,14 in order with no loss.
- **Reset mid-stream:** drop in_RSTB with 3 beats in flight. Expect out_VALID=0, out_S=0, out_CO=0 immediately. After release, no stale beat appears and the next accepted beat emerges after 4 edges.
